btn_reader: RTL and testbench
=============================

# btn_reader

Debounced pushbutton/switch input reader for the board I/O path, the input-side counterpart of the prescaled LED pattern writers. It synchronises raw button levels to `iCLK`, debounces each bit on a shared slow sampling tick, and emits a clean level plus one-clock press and release pulses. Downstream pattern and LED logic consumes these pulses instead of raw pins.

## Interface
Parameters:
- `N_BTN`, default 4: number of button inputs.
- `TICK_DIV`, default 19: prescaler width. The sample tick occurs every 2^TICK_DIV clocks.
- `DEB_TICKS`, default 4: number of consecutive equal samples needed to accept a level change. Minimum 1.
- `REP_DELAY`, default 32: autorepeat delay, in ticks from acceptance of a press to the first repeat. Used only with the macro.
- `REP_RATE`, default 8: autorepeat period, in ticks between later repeats. Used only with the macro.

Ports:
- `iCLK` in 1: the single clock. All logic is on its rising edge.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iBTN` in N_BTN: raw button levels, active-high, asynchronous to `iCLK`.
- `oLEVEL` out N_BTN: debounced level.
- `oPRESS` out N_BTN: one-clock pulse on each accepted press, and on each autorepeat.
- `oRELEASE` out N_BTN: one-clock pulse on each accepted release.
- `oTICK` out 1: the sample tick, a one-clock pulse, for use by other blocks.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each bit, reset to 0. Debounce logic sees only the synchronised value `s`.
- **Prescaler:** free-running counter, TICK_DIV bits wide, reset to 0, wraps naturally. The tick is asserted in the cycle where the count is all ones.
- **Per-bit FSM:** states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. There is a sample counter `cnt`, wide enough to hold DEB_TICKS. The FSM acts only on tick cycles:
  - IDLE: if `s`=1, set `cnt`=1 and go to PRESS_WAIT. If DEB_TICKS=1, go directly to HELD instead.
  - PRESS_WAIT: if `s`=1, increment `cnt`. When `cnt` reaches DEB_TICKS, go to HELD, set `oLEVEL`=1 and pulse `oPRESS`. If `s`=0, return to IDLE.
  - HELD: if `s`=0, go to RELEASE_WAIT with `cnt`=1.
  - RELEASE_WAIT: if `s`=0, increment `cnt`. When `cnt` reaches DEB_TICKS, go to IDLE, set `oLEVEL`=0 and pulse `oRELEASE`. If `s`=1, return to HELD with no pulse.
- **Bit independence:** bits are fully independent. Several bits may pulse in the same cycle.
- **No overlap on one bit:** `oPRESS` and `oRELEASE` are never both high on the same bit.
- **No glitches:** `oLEVEL` changes only together with a pulse on that bit.

## Timing
- **Reset values:** all outputs, all states (IDLE) and all counters are 0 while `iRST_N`=0, entered asynchronously.
- **Reset deassertion:** no pulse is generated by reset itself. A button held through reset is seen as a fresh press afterwards.
- **Reset mid-operation:** everything is aborted. No `oRELEASE` is issued for buttons that were HELD.
- **Output latency:** outputs are registered. The pulse and level change appear in the cycle after the tick cycle that accepted the change.
- **Worst-case acceptance latency:** 2 sync clocks + DEB_TICKS×2^TICK_DIV + 1 clocks.
- **`oTICK`:** combinational from the prescaler compare, and registered-equivalent, since the counter is a register.

## Configuration
- Macro `BTN_READER_AUTOREPEAT_EN`.
- **Defined:** in HELD, a repeat counter is cleared on entry to HELD and counts ticks. `oPRESS` pulses again REP_DELAY ticks after acceptance, then every REP_RATE ticks, while the FSM stays in HELD. The counter is not cleared by a RELEASE_WAIT bounce that returns to HELD.
- **Undefined:** exactly one `oPRESS` per accepted press. No repeat counter is synthesised.

## Structure
- Package `btn_reader_pkg`: the FSM state enum, and default localparams for DEB_TICKS, REP_DELAY and REP_RATE.
- Sub-module `btn_debounce_ch`: one channel (synchroniser, FSM, counters, autorepeat), instantiated N_BTN times via generate.
- The top level holds the shared prescaler and drives the tick into every channel.

## Test plan
All scenarios use TICK_DIV=2 (tick every 4 clocks), DEB_TICKS=3, REP_DELAY=4, REP_RATE=2.
1. Reset held 10 clocks -> all outputs 0. After release, `oTICK` first pulses at clock 3 post-deassertion.
2. `iBTN[0]` 0→1, held 40 clocks -> exactly one `oPRESS[0]`. `oLEVEL[0]` is 1 within 2+12+1=15 clocks of the edge. `oRELEASE` stays 0.
3. `iBTN[1]` toggled every 3 clocks for 30 clocks, then held 0 -> no pulses on bit 1, and `oLEVEL[1]` stays 0.
4. After scenario 2, `iBTN[0]` 1→0 -> exactly one `oRELEASE[0]` within 15 clocks, and `oLEVEL[0]`=0.
5. `iBTN[2]` held 100 clocks:
   - with macro: `oPRESS[2]` at acceptance, then +16 clocks, then every 8 clocks.
   - without macro: exactly one pulse.
6. Reset asserted while bit 3 is HELD -> `oLEVEL[3]`=0 immediately, with no `oRELEASE`. After deassertion with the button still held -> one new `oPRESS[3]`.

Source files
------------

// File: rtl/btn_reader_pkg.sv
// Shared types and default tuning values for the debounced button reader.
package btn_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEB_TICKS_DEF = 4;
    localparam int REP_DELAY_DEF = 32;
    localparam int REP_RATE_DEF  = 8;

endpackage : btn_reader_pkg

// File: rtl/btn_reader_if.sv
// Button reader bus: raw levels in, debounced level/pulses and sample tick out.
interface btn_reader_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] iBTN;
    logic [N_BTN-1:0] oLEVEL;
    logic [N_BTN-1:0] oPRESS;
    logic [N_BTN-1:0] oRELEASE;
    logic             oTICK;

    modport master (output iBTN, input oLEVEL, oPRESS, oRELEASE, oTICK);
    modport slave  (input iBTN, output oLEVEL, oPRESS, oRELEASE, oTICK);
endinterface : btn_reader_if

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM, registered pulses.
// Autorepeat while held is built only when BTN_READER_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_reader_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int REP_DELAY = REP_DELAY_DEF,
    parameter int REP_RATE  = REP_RATE_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CNT_W = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_TICKS);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s       = sync2_q;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef BTN_READER_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // rep_first_q selects the initial delay versus the steady repeat period
    logic [REP_W-1:0] rep_q, rep_d, rep_inc, rep_target;
    logic             rep_first_q, rep_first_d;

    assign rep_inc    = rep_q + 1'b1;
    assign rep_target = rep_first_q ? REP_W'(REP_RATE) : REP_W'(REP_DELAY);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_READER_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (tick_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        if (DEB_TICKS == 1) begin
                            state_d = ST_HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
`ifdef BTN_READER_AUTOREPEAT_EN
                            rep_d       = '0;
                            rep_first_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == DEB_MAX) begin
                        state_d = ST_HELD;
                        cnt_d   = cnt_inc;
                        level_d = 1'b1;
                        press_d = 1'b1;
`ifdef BTN_READER_AUTOREPEAT_EN
                        rep_d       = '0;
                        rep_first_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        if (DEB_TICKS == 1) begin
                            state_d   = ST_IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
`ifdef BTN_READER_AUTOREPEAT_EN
                    else if (rep_inc == rep_target) begin
                        press_d     = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                ST_RELEASE_WAIT: begin
                    // a bounce back to HELD keeps the repeat phase running
                    if (s) begin
                        state_d = ST_HELD;
                    end else if (cnt_inc == DEB_MAX) begin
                        state_d   = ST_IDLE;
                        cnt_d     = cnt_inc;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_READER_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef BTN_READER_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : btn_debounce_ch

// File: rtl/btn_reader.sv
// Debounced button reader top: shared sample-tick prescaler feeding N_BTN channels.
// Define BTN_READER_AUTOREPEAT_EN to add autorepeat pulses on held buttons.
module btn_reader
    import btn_reader_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = 19,
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int REP_DELAY = REP_DELAY_DEF,
    parameter int REP_RATE  = REP_RATE_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    btn_reader_if.slave      bus
);
    logic [TICK_DIV-1:0] div_q, div_d;
    logic                tick;
    logic [N_BTN-1:0]    level_w, press_w, release_w;

    assign div_d = div_q + 1'b1;
    assign tick  = &div_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEB_TICKS (DEB_TICKS),
            .REP_DELAY (REP_DELAY),
            .REP_RATE  (REP_RATE)
        ) u_ch (
            .clk_i     (iCLK),
            .rst_ni    (iRST_N),
            .tick_i    (tick),
            .btn_i     (bus.iBTN[gi]),
            .level_o   (level_w[gi]),
            .press_o   (press_w[gi]),
            .release_o (release_w[gi])
        );
    end

    assign bus.oLEVEL   = level_w;
    assign bus.oPRESS   = press_w;
    assign bus.oRELEASE = release_w;
    assign bus.oTICK    = tick;

endmodule : btn_reader

// File: tb/tb_btn_reader.sv
// Self-checking bench for btn_reader: directed scenarios plus random button activity
// compared cycle by cycle against a sample-history reference model.
module tb_btn_reader;
    localparam int N      = 4;
    localparam int TDIV   = 2;
    localparam int PERIOD = 1 << TDIV;
    localparam int DEB    = 3;
    localparam int RDLY   = 4;
    localparam int RRATE  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;

    btn_reader_if #(.N_BTN(N)) bif ();

    btn_reader #(
        .N_BTN     (N),
        .TICK_DIV  (TDIV),
        .DEB_TICKS (DEB),
        .REP_DELAY (RDLY),
        .REP_RATE  (RRATE)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    // reference model state: level per bit, run of disagreeing tick samples, held ticks
    int         m_tick_cnt;
    logic [N-1:0] m_d1, m_d2;
    logic [N-1:0] m_level;
    int         m_run [N];
    int         m_rep [N];
    logic [N-1:0] exp_press, exp_rel;
    logic       exp_tick;
    int         cnt_press [N];
    int         cnt_rel [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tick_cnt = 0;
        m_d1 = '0;
        m_d2 = '0;
        m_level = '0;
        exp_press = '0;
        exp_rel = '0;
        exp_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_rep[i] = 0;
        end
    endtask

    // one rising edge of the model; b is the raw input present at that edge
    task automatic model_edge(input logic [N-1:0] b);
        bit           tick_now;
        bit           steady;
        logic [N-1:0] s;
        tick_now  = (m_tick_cnt % PERIOD) == PERIOD - 1;
        s         = m_d2;
        exp_press = '0;
        exp_rel   = '0;
        if (tick_now) begin
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = s[i];
                        m_run[i] = 0;
                        if (s[i]) begin
                            exp_press[i] = 1'b1;
                            m_rep[i] = 0;
                        end else begin
                            exp_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    steady = (m_run[i] == 0);
                    m_run[i] = 0;
`ifdef BTN_READER_AUTOREPEAT_EN
                    if (m_level[i] && steady) begin
                        m_rep[i]++;
                        if (m_rep[i] >= RDLY && ((m_rep[i] - RDLY) % RRATE) == 0)
                            exp_press[i] = 1'b1;
                    end
`else
                    if (steady) m_rep[i] = 0;
`endif
                end
            end
        end
        m_d2 = m_d1;
        m_d1 = b;
        m_tick_cnt++;
        exp_tick = (m_tick_cnt % PERIOD) == PERIOD - 1;
    endtask

    task automatic step();
        logic [N-1:0] b;
        b = bif.iBTN;
        @(posedge clk);
        #1;
        model_edge(b);
        chk("level", 32'(bif.oLEVEL), 32'(m_level));
        chk("press", 32'(bif.oPRESS), 32'(exp_press));
        chk("release", 32'(bif.oRELEASE), 32'(exp_rel));
        chk("tick", 32'(bif.oTICK), 32'(exp_tick));
        chk("overlap", 32'(bif.oPRESS & bif.oRELEASE), 32'd0);
        for (int i = 0; i < N; i++) begin
            cnt_press[i] += int'(bif.oPRESS[i]);
            cnt_rel[i]   += int'(bif.oRELEASE[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i] = 0;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input int n);
        repeat (n) begin
            bif.iBTN = v;
            step();
        end
    endtask

    task automatic apply_reset(input int n);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_level", 32'(bif.oLEVEL), 32'd0);
        chk("rst_async_pulse", 32'(bif.oPRESS | bif.oRELEASE), 32'd0);
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_hold_out", {bif.oLEVEL, bif.oPRESS, bif.oRELEASE, 3'b000, bif.oTICK}, 32'd0);
            for (int i = 0; i < N; i++) cnt_rel[i] += int'(bif.oRELEASE[i]);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] v;
        int           rate;
        bif.iBTN = '0;
        clear_counts();

        // 1: reset, then tick phase
        apply_reset(10);
        drive('0, 8);

        // 2: bit0 pressed and held
        clear_counts();
        drive(4'b0001, 40);
`ifndef BTN_READER_AUTOREPEAT_EN
        chk("sc2_press_cnt", 32'(cnt_press[0]), 32'd1);
`endif
        chk("sc2_rel_cnt", 32'(cnt_rel[0]), 32'd0);

        // 3: bit1 chatters every 3 clocks, must never be accepted
        clear_counts();
        for (int k = 0; k < 10; k++) drive({2'b00, k[0], 1'b1}, 3);
        drive(4'b0001, 20);
        chk("sc3_b1_pulses", 32'(cnt_press[1] + cnt_rel[1]), 32'd0);
        chk("sc3_b1_level", 32'(bif.oLEVEL[1]), 32'd0);

        // 4: bit0 released
        clear_counts();
        drive(4'b0000, 20);
        chk("sc4_rel_cnt", 32'(cnt_rel[0]), 32'd1);
        chk("sc4_level", 32'(bif.oLEVEL[0]), 32'd0);

        // 5: bit2 held 100 clocks
        clear_counts();
        drive(4'b0100, 100);
`ifndef BTN_READER_AUTOREPEAT_EN
        chk("sc5_press_cnt", 32'(cnt_press[2]), 32'd1);
`endif
        drive(4'b0000, 20);

        // 6: reset while bit3 held, button stays held through reset
        drive(4'b1000, 30);
        chk("sc6_held", 32'(bif.oLEVEL[3]), 32'd1);
        clear_counts();
        bif.iBTN = 4'b1000;
        apply_reset(5);
        drive(4'b1000, 20);
        chk("sc6_no_release", 32'(cnt_rel[3]), 32'd0);
        chk("sc6_repress", 32'(cnt_press[3] > 0), 32'd1);
        drive(4'b0000, 20);

        // random activity: alternate chattery and calm segments, occasional reset
        v = '0;
        for (int seg = 0; seg < 12; seg++) begin
            rate = (seg % 2 == 0) ? 6 : 30;
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, rate - 1) == 0) v[i] = ~v[i];
                bif.iBTN = v;
                step();
            end
            if (seg % 5 == 4) apply_reset($urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule : tb_btn_reader
